// File: rtl/mca_pkg.sv
// Shared types and helpers for the multichannel-analyser histogram.
package mca_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } mca_state_t;

  // Saturating increment of the low `width` bits (width up to 63).
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    if ((value & mask) == mask) begin
      sat_inc = mask;
    end else begin
      sat_inc = (value + 64'd1) & mask;
    end
  endfunction

endpackage

// File: rtl/mca_ram.sv
// Simple dual-port RAM: one write port, one registered read port, old data on read-during-write.
module mca_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; the output register alone is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/mca_histogram.sv
// Histogram memory: one saturating counter per channel, STOP/RUN/CLEAR control,
// two-stage increment pipeline with write forwarding, and a separate readout copy.
module mca_histogram
  import mca_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              cmd_pause,
  input  logic              cmd_clear,
  input  logic              event_valid,
  input  logic [ADDR_W-1:0] event_channel,
  input  logic [ADDR_W-1:0] channel_address,
  output logic [CNT_W-1:0]  channel_count,
  output logic              running,
  output logic              clearing,
  output logic [CNT_W-1:0]  total_events
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  mca_state_t        state_r;
  logic [ADDR_W-1:0] sweep_r;
  logic              running_r;
  logic              clearing_r;
  logic [CNT_W-1:0]  total_r;

  logic              accept_s;
  logic              s1_valid_r;
  logic [ADDR_W-1:0] s1_addr_r;
  logic              fwd_valid_r;
  logic [ADDR_W-1:0] fwd_addr_r;
  logic [CNT_W-1:0]  fwd_data_r;
  logic [ADDR_W-1:0] rd_addr_r;

  logic [CNT_W-1:0]  ram_a_rdata_s;
  logic [CNT_W-1:0]  src_s;
  logic [CNT_W-1:0]  sum_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [CNT_W-1:0]  wdata_s;

  assign accept_s = event_valid && (state_r == ST_RUN) && !cmd_clear;

  // Control FSM with registered status flags; clear beats pause beats start.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_STOP;
      sweep_r    <= '0;
      running_r  <= 1'b0;
      clearing_r <= 1'b0;
    end else begin
      case (state_r)
        ST_STOP: begin
          if (cmd_clear) begin
            state_r    <= ST_CLEAR;
            sweep_r    <= '0;
            clearing_r <= 1'b1;
          end else if (cmd_start) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cmd_clear) begin
            state_r    <= ST_CLEAR;
            sweep_r    <= '0;
            running_r  <= 1'b0;
            clearing_r <= 1'b1;
          end else if (cmd_pause) begin
            state_r   <= ST_STOP;
            running_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (cmd_clear) begin
            sweep_r <= '0;
          end else if (sweep_r == LAST_ADDR) begin
            state_r    <= ST_STOP;
            clearing_r <= 1'b0;
          end else begin
            sweep_r <= sweep_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r    <= ST_STOP;
          sweep_r    <= '0;
          running_r  <= 1'b0;
          clearing_r <= 1'b0;
        end
      endcase
    end
  end

  // Stage-1 source select and shared write-port mux (sweep owns the port during CLEAR).
  always_comb begin
    src_s = ram_a_rdata_s;
    if (fwd_valid_r && (fwd_addr_r == s1_addr_r)) begin
      src_s = fwd_data_r;
    end else begin
      src_s = ram_a_rdata_s;
    end
    sum_s = CNT_W'(sat_inc(64'(src_s), CNT_W));
    if (state_r == ST_CLEAR) begin
      we_s    = 1'b1;
      waddr_s = sweep_r;
      wdata_s = '0;
    end else begin
      we_s    = s1_valid_r;
      waddr_s = s1_addr_r;
      wdata_s = sum_s;
    end
  end

  // Increment pipeline, forwarding register, event total and readout address.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_addr_r   <= '0;
      fwd_valid_r <= 1'b0;
      fwd_addr_r  <= '0;
      fwd_data_r  <= '0;
      total_r     <= '0;
      rd_addr_r   <= '0;
    end else begin
      s1_valid_r  <= accept_s;
      s1_addr_r   <= event_channel;
      // Sweep writes are not forwarded, so a stale entry must not outlive CLEAR.
      fwd_valid_r <= (state_r == ST_CLEAR) ? 1'b0 : s1_valid_r;
      fwd_addr_r  <= s1_addr_r;
      fwd_data_r  <= sum_s;
      rd_addr_r   <= channel_address;
      if (cmd_clear) begin
        total_r <= '0;
      end else if (accept_s) begin
        total_r <= CNT_W'(sat_inc(64'(total_r), CNT_W));
      end
    end
  end

  mca_ram #(.ADDR_W(ADDR_W), .DATA_W(CNT_W)) u_ram_a (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (event_channel),
    .rdata (ram_a_rdata_s)
  );

  mca_ram #(.ADDR_W(ADDR_W), .DATA_W(CNT_W)) u_ram_b (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (rd_addr_r),
    .rdata (channel_count)
  );

  assign running      = running_r;
  assign clearing     = clearing_r;
  assign total_events = total_r;

endmodule

// File: tb/tb_mca_histogram.sv
// Directed self-checking bench for mca_histogram (default widths plus a 4-bit counter instance).
module tb_mca_histogram;

  logic        CLOCK_50;
  logic        rst_n;
  logic        cmd_start, cmd_pause, cmd_clear, event_valid;
  logic [9:0]  event_channel, channel_address;
  logic [31:0] channel_count, total_events;
  logic        running, clearing;

  logic        d4_start, d4_pause, d4_clear, d4_valid;
  logic [1:0]  d4_ch, d4_addr;
  logic [3:0]  d4_count, d4_total;
  logic        d4_running, d4_clearing;

  int total_cnt;
  int bad_cnt;

  mca_histogram dut (
    .CLOCK_50        (CLOCK_50),
    .rst_n           (rst_n),
    .cmd_start       (cmd_start),
    .cmd_pause       (cmd_pause),
    .cmd_clear       (cmd_clear),
    .event_valid     (event_valid),
    .event_channel   (event_channel),
    .channel_address (channel_address),
    .channel_count   (channel_count),
    .running         (running),
    .clearing        (clearing),
    .total_events    (total_events)
  );

  mca_histogram #(.ADDR_W(2), .CNT_W(4)) dut4 (
    .CLOCK_50        (CLOCK_50),
    .rst_n           (rst_n),
    .cmd_start       (d4_start),
    .cmd_pause       (d4_pause),
    .cmd_clear       (d4_clear),
    .event_valid     (d4_valid),
    .event_channel   (d4_ch),
    .channel_address (d4_addr),
    .channel_count   (d4_count),
    .running         (d4_running),
    .clearing        (d4_clearing),
    .total_events    (d4_total)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    if (got !== exp) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] v);
    channel_address = a;
    tick();
    tick();
    v = channel_count;
  endtask

  task automatic ev(input logic [9:0] ch);
    event_valid   = 1'b1;
    event_channel = ch;
    tick();
    event_valid   = 1'b0;
  endtask

  task automatic count_clearing(output int n);
    n = 0;
    while (clearing && n < 2000) begin
      n = n + 1;
      tick();
    end
  endtask

  initial begin
    logic [31:0] v;
    int n;
    int nz;
    int run_seen;

    total_cnt = 0;
    bad_cnt   = 0;
    rst_n = 1'b0;
    cmd_start = 1'b0; cmd_pause = 1'b0; cmd_clear = 1'b0; event_valid = 1'b0;
    event_channel = 10'd0; channel_address = 10'd0;
    d4_start = 1'b0; d4_pause = 1'b0; d4_clear = 1'b0; d4_valid = 1'b0;
    d4_ch = 2'd0; d4_addr = 2'd0;
    tick();
    tick();
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_clearing", 64'(clearing), 64'd0);
    chk("rst_total", 64'(total_events), 64'd0);
    chk("rst_count", 64'(channel_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Initial clear sweep
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    count_clearing(n);
    chk("clr0_len", 64'(n), 64'd1024);
    chk("clr0_running", 64'(running), 64'd0);

    // Three back-to-back events on channel 5
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    chk("start_running", 64'(running), 64'd1);
    event_valid = 1'b1; event_channel = 10'd5;
    tick(); tick(); tick();
    event_valid = 1'b0;
    tick(); tick();
    chk("ch5_total", 64'(total_events), 64'd3);
    rd(10'd5, v); chk("ch5_count", 64'(v), 64'd3);
    chk("ch5_running", 64'(running), 64'd1);

    // Forwarding hazard: 7,7,8,7 back-to-back
    event_valid = 1'b1;
    event_channel = 10'd7; tick();
    event_channel = 10'd7; tick();
    event_channel = 10'd8; tick();
    event_channel = 10'd7; tick();
    event_valid = 1'b0;
    tick(); tick();
    rd(10'd7, v); chk("fwd_ch7", 64'(v), 64'd3);
    rd(10'd8, v); chk("fwd_ch8", 64'(v), 64'd1);
    rd(10'd6, v); chk("fwd_ch6", 64'(v), 64'd0);
    rd(10'd9, v); chk("fwd_ch9", 64'(v), 64'd0);
    chk("fwd_total", 64'(total_events), 64'd7);

    // Pause with a simultaneous event, then 10 dropped events
    cmd_pause = 1'b1; event_valid = 1'b1; event_channel = 10'd2;
    tick();
    cmd_pause = 1'b0;
    chk("pause_running", 64'(running), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    event_valid = 1'b0;
    tick(); tick();
    rd(10'd2, v); chk("pause_ch2", 64'(v), 64'd1);
    chk("pause_total", 64'(total_events), 64'd8);

    // 100 spread events, then clear while events keep arriving
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    event_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      event_channel = 10'(i * 37 + 3);
      tick();
    end
    chk("spread_total", 64'(total_events), 64'd108);
    cmd_clear = 1'b1; event_channel = 10'd11;
    tick();
    cmd_clear = 1'b0;
    n = 0;
    while (clearing && n < 2000) begin
      n = n + 1;
      event_channel = 10'(n * 13);
      tick();
    end
    chk("clr_len", 64'(n), 64'd1024);
    tick(); tick(); tick();
    event_valid = 1'b0;
    chk("clr_total", 64'(total_events), 64'd0);
    chk("clr_running", 64'(running), 64'd0);
    chk("clr_clearing", 64'(clearing), 64'd0);
    nz = 0;
    for (int a = 0; a < 1024; a++) begin
      rd(10'(a), v);
      if (v != 32'd0) nz = nz + 1;
    end
    chk("clr_all_zero", 64'(nz), 64'd0);

    // Saturation on the 4-bit instance
    d4_clear = 1'b1;
    tick();
    d4_clear = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    d4_start = 1'b1;
    tick();
    d4_start = 1'b0;
    d4_valid = 1'b1; d4_ch = 2'd0;
    for (int i = 0; i < 20; i++) tick();
    d4_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("sat_count", 64'(d4_count), 64'd15);
    chk("sat_total", 64'(d4_total), 64'd15);

    // Seed a visible count, then start+clear together and reset mid-sweep
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    ev(10'd1000);
    ev(10'd1000);
    cmd_pause = 1'b1;
    tick();
    cmd_pause = 1'b0;
    rd(10'd1000, v); chk("seed_ch1000", 64'(v), 64'd2);
    chk("seed_total", 64'(total_events), 64'd2);
    cmd_start = 1'b1; cmd_clear = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_clear = 1'b0;
    chk("sc_clearing", 64'(clearing), 64'd1);
    run_seen = 0;
    if (running) run_seen = run_seen + 1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (running) run_seen = run_seen + 1;
    end
    chk("sc_never_run", 64'(run_seen), 64'd0);
    chk("sc_mid_clearing", 64'(clearing), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_running", 64'(running), 64'd0);
    chk("mrst_clearing", 64'(clearing), 64'd0);
    chk("mrst_total", 64'(total_events), 64'd0);
    chk("mrst_count", 64'(channel_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_clearing", 64'(clearing), 64'd0);
    chk("post_rst_running", 64'(running), 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mca_histogram.md
# mca_histogram

Multichannel-analyser histogram memory, the responder end of the USB command and channel-readout interface. It receives `cmd_start`, `cmd_pause` and `cmd_clear` pulses from the USB command decoder and keeps one saturating event counter per channel. It increments those counters from a pulse-height event stream and returns `channel_count` for the `channel_address` requested by the USB uploader. It sits between the detector front-end (ADC/discriminator) and the USB command block on the `CLOCK_50` domain.

## Interface
- `ADDR_W`, default 10: channel address width, giving 2^ADDR_W channels.
- `CNT_W`, default 32: counter width.

- `CLOCK_50` in 1: the single clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_start` in 1: one-cycle pulse, begin acquisition.
- `cmd_pause` in 1: one-cycle pulse, stop acquisition, counts kept.
- `cmd_clear` in 1: one-cycle pulse, zero all counters.
- `event_valid` in 1: event strobe, up to one per cycle.
- `event_channel` in ADDR_W: channel of the event.
- `channel_address` in ADDR_W: readout address from the USB side.
- `channel_count` out CNT_W: counter value at the registered `channel_address`.
- `running` out 1: high in RUN.
- `clearing` out 1: high in CLEAR.
- `total_events` out CNT_W: events accepted since the last clear, saturating.

## Operation
- The state machine has three states: STOP, RUN and CLEAR. Reset state is STOP.
- Command priority within one cycle is clear > pause > start.
  - STOP + `cmd_start` → RUN.
  - RUN + `cmd_pause` → STOP.
  - Any state + `cmd_clear` → CLEAR, with the sweep address reset to 0.
  - CLEAR restarts its sweep if `cmd_clear` arrives again. `cmd_start` and `cmd_pause` are ignored during CLEAR.
  - At the end of the sweep the block goes to STOP.
- An event is accepted iff `event_valid`, the registered state is RUN, and `cmd_clear` is low in the same cycle.
  - An event arriving in the same cycle as `cmd_pause` is counted.
  - Events that are not accepted are dropped silently.
- Increment pipeline:
  - Cycle t: the event is accepted and the count RAM read address is set to `event_channel`.
  - Cycle t+1: the RAM data arrives and `sum = sat(src + 1)` is computed.
  - `sum` is written at the closing edge of t+1.
- RAM read-during-write returns old data. A forwarding register holds the address and data of the previous cycle's write. When the stage-1 address matches it, `src` is taken from the forwarding register; otherwise `src` is the RAM data.
- Saturation: a counter at all-ones stays at all-ones. `total_events` saturates the same way and is zeroed on entry to CLEAR.
- CLEAR sweep:
  - Writes 0 to address 0 … 2^ADDR_W−1, one per cycle.
  - An increment write still in flight from an event accepted before the clear completes normally and is overwritten later by the sweep.
  - The forwarding register is invalidated during CLEAR.
- Readout path:
  - Every write, whether increment or clear, goes to two RAM copies.
  - Copy A serves the increment read. Copy B serves `channel_address`.
  - Readout has no forwarding, so it may lag an increment by 1 cycle.
- Reset in mid-operation:
  - All registers return to reset values: STOP, `running` = `clearing` = 0, `total_events` = 0, `channel_count` = 0.
  - RAM contents are undefined; software issues `cmd_clear` after reset.

## Timing
- Event throughput: one event per cycle, sustained, to any channel mix, including repeats of the same channel.
- Event-to-RAM-commit latency: 2 edges.
- `total_events` updates 1 cycle after acceptance.
- Readout: `channel_address` is sampled at edge n and `channel_count` is valid after edge n+1 (1-cycle registered read). It reflects writes committed by edge n.
- `clearing` rises at the edge after `cmd_clear` and stays high for exactly 2^ADDR_W cycles. The state is STOP in the following cycle.
- `running` changes at the edge after the command pulse.

## Structure
- A shared package `mca_pkg` holds:
  - The state enum (STOP, RUN, CLEAR).
  - The ADDR_W/CNT_W defaults.
  - A saturating-increment function.
- The natural sub-module is `mca_ram`: simple dual port, one write port plus one registered read port, old-data read-during-write. It is instantiated twice (copies A and B). Everything else lives in `mca_histogram`.

## Test plan
- Reset, `cmd_clear`, wait 1024 cycles, `cmd_start`, then 3 back-to-back events on ch 5 → `channel_count`@5 = 3, `total_events` = 3, `running` = 1.
- Back-to-back events on ch 7, 7, 8, 7 (forwarding hazard) → ch 7 = 3, ch 8 = 1, ch 6/9 = 0.
- `cmd_pause` with a simultaneous event on ch 2, then 10 further events on ch 2 → ch 2 = 1, `running` = 0, `total_events` unchanged by the dropped 10.
- Run 100 events spread over ch 0–1023, then `cmd_clear` while events continue → `clearing` high for exactly 1024 cycles, every channel reads 0 afterwards, the block ends in STOP, `total_events` = 0.
- With CNT_W=4, 20 events on ch 0 → ch 0 = 15 and `total_events` = 15 (saturated).
- `cmd_start` and `cmd_clear` in the same cycle → CLEAR then STOP, `running` never asserted. Assert `rst_n` mid-sweep → immediate STOP, all outputs 0.
